// File: rtl/tone_pkg.sv
// Shared types, segment codes and the tone reduction rule for the
// tone contour classifier.
package tone_pkg;

  typedef enum logic [2:0] {
    TONE_NEUTRAL    = 3'b000,
    TONE_RISING     = 3'b001,
    TONE_UNDULATING = 3'b010,
    TONE_FALLING    = 3'b100
  } tone_e;

  localparam logic [1:0] SEG_FLAT = 2'b00;
  localparam logic [1:0] SEG_RISE = 2'b01;
  localparam logic [1:0] SEG_FALL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CALC,
    ST_REPORT
  } state_e;

  // Rise/fall tallies; at most 15 segments in the deepest window.
  typedef logic [4:0] seg_cnt_t;

  function automatic tone_e classify(input seg_cnt_t rises, input seg_cnt_t falls);
    logic [5:0] total;
    total = {1'b0, rises} + {1'b0, falls};
    if (total < 6'd2) return TONE_NEUTRAL;
    if (falls == '0 || rises > falls) return TONE_RISING;
    if (rises == '0 || falls > rises) return TONE_FALLING;
    return TONE_UNDULATING;
  endfunction

endpackage

// File: rtl/tone_change_detector.sv
// Combinational rise/fall/flat decision for one pair of pitch estimates,
// using a cross-multiplied percentage test instead of a divider.
module tone_change_detector
  import tone_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int THRESH_PCT = 20
) (
  input  logic [DATA_W-1:0] prev_i,
  input  logic [DATA_W-1:0] cur_i,
  output logic [1:0]        code_o
);

  // 7 extra bits hold a factor of up to 100 without overflow.
  localparam int PROD_W = DATA_W + 7;

  logic              rising;
  logic [DATA_W-1:0] diff;
  logic [PROD_W-1:0] lhs;
  logic [PROD_W-1:0] rhs;

  // NOTE: combinational logic uses blocking (=) assignments and gives every
  // output a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    code_o = SEG_FLAT;
    rising = cur_i > prev_i;
    diff   = rising ? cur_i - prev_i : prev_i - cur_i;
    lhs    = PROD_W'(diff) * PROD_W'(100);
    rhs    = PROD_W'(prev_i) * PROD_W'(THRESH_PCT);
    // diff != 0 keeps an unchanged zero pitch from counting as significant.
    if (diff != '0 && lhs >= rhs) begin
      code_o = rising ? SEG_RISE : SEG_FALL;
    end
  end

endmodule

// File: rtl/tone_contour_classifier.sv
// Windowed pitch-contour classifier: captures NUM_FRAMES estimates, grades each
// adjacent pair with one shared detector, and reduces the codes to a tone id.
module tone_contour_classifier
  import tone_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_FRAMES = 4,
  parameter int THRESH_PCT = 20
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic                        continuous_in,
  input  logic                        frame_valid_in,
  input  logic [DATA_W-1:0]           frame_data_in,
  output logic                        frame_ready_out,
  output logic                        busy_out,
  output logic [2*(NUM_FRAMES-1)-1:0] contour_out,
  output logic [2:0]                  tone_ident_out,
  output logic                        valid_out
);

  localparam int SEGS  = NUM_FRAMES - 1;
  localparam int CNT_W = $clog2(NUM_FRAMES + 1);
  localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;

  state_e            state_q, state_d;
  logic              cont_q, cont_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  seg_cnt_t          rise_q, rise_d;
  seg_cnt_t          fall_q, fall_d;
  logic [2*SEGS-1:0] work_q, work_d;
  logic [2*SEGS-1:0] contour_q, contour_d;
  tone_e             tone_q, tone_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] win_q [NUM_FRAMES];
  logic [DATA_W-1:0] win_d [NUM_FRAMES];

  logic [DATA_W-1:0] prev_sel;
  logic [DATA_W-1:0] cur_sel;
  logic [1:0]        seg_code;
  logic              accept;

  assign frame_ready_out = (state_q == ST_CAPTURE);
  assign busy_out        = (state_q != ST_IDLE);
  assign accept          = frame_valid_in && frame_ready_out;
  assign contour_out     = contour_q;
  assign tone_ident_out  = tone_q;
  assign valid_out       = valid_q;

  always_comb begin
    prev_sel = win_q[0];
    cur_sel  = win_q[1];
    for (int i = 0; i < SEGS; i++) begin
      if (seg_q == SEG_W'(i)) begin
        prev_sel = win_q[i];
        cur_sel  = win_q[i+1];
      end
    end
  end

  tone_change_detector #(
    .DATA_W    (DATA_W),
    .THRESH_PCT(THRESH_PCT)
  ) u_detector (
    .prev_i(prev_sel),
    .cur_i (cur_sel),
    .code_o(seg_code)
  );

  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    count_d   = count_q;
    seg_d     = seg_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    work_d    = work_q;
    contour_d = contour_q;
    tone_d    = tone_q;
    valid_d   = 1'b0;
    win_d     = win_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          cont_d  = continuous_in;
          count_d = '0;
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (accept) begin
          for (int i = 0; i < NUM_FRAMES - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[NUM_FRAMES-1] = frame_data_in;
          count_d             = count_q + CNT_W'(1);
          if (count_q == CNT_W'(NUM_FRAMES - 1)) begin
            state_d = ST_CALC;
            seg_d   = '0;
            rise_d  = '0;
            fall_d  = '0;
            work_d  = '0;
          end
        end
      end

      ST_CALC: begin
        for (int i = 0; i < SEGS; i++) begin
          if (seg_q == SEG_W'(i)) work_d[2*i +: 2] = seg_code;
        end
        if (seg_code == SEG_RISE) rise_d = rise_q + seg_cnt_t'(1);
        if (seg_code == SEG_FALL) fall_d = fall_q + seg_cnt_t'(1);
        if (seg_q == SEG_W'(SEGS - 1)) state_d = ST_REPORT;
        else                           seg_d   = seg_q + SEG_W'(1);
      end

      ST_REPORT: begin
        contour_d = work_q;
        tone_d    = classify(rise_q, fall_q);
        valid_d   = 1'b1;
        // Sliding mode keeps the newest SEGS frames; one more closes the window.
        if (cont_q) begin
          count_d = CNT_W'(NUM_FRAMES - 1);
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      cont_q    <= 1'b0;
      count_q   <= '0;
      seg_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      work_q    <= '0;
      contour_q <= '0;
      tone_q    <= TONE_NEUTRAL;
      valid_q   <= 1'b0;
      // NOTE: the window is a handful of flops, not a RAM macro, so it is
      // cleared by reset; a true memory array would be left unreset.
      for (int i = 0; i < NUM_FRAMES; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      count_q   <= count_d;
      seg_q     <= seg_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      work_q    <= work_d;
      contour_q <= contour_d;
      tone_q    <= tone_d;
      valid_q   <= valid_d;
      win_q     <= win_d;
    end
  end

endmodule

// File: tb/tb_tone_contour_classifier.sv
// Directed bench for tone_contour_classifier: default build plus NUM_FRAMES=2
// and NUM_FRAMES=16 builds at DATA_W=32 with values near full scale.
module tb_tone_contour_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s0_start, s0_cont, s0_fv;
  logic [15:0] s0_fd;
  logic        s0_rdy, s0_busy, s0_valid;
  logic [5:0]  s0_contour;
  logic [2:0]  s0_tone;

  logic        sa_start, sa_fv;
  logic [31:0] sa_fd;
  logic        sa_rdy, sa_busy, sa_valid;
  logic [1:0]  sa_contour;
  logic [2:0]  sa_tone;

  logic        sb_start, sb_fv;
  logic [31:0] sb_fd;
  logic        sb_rdy, sb_busy, sb_valid;
  logic [29:0] sb_contour;
  logic [2:0]  sb_tone;

  int n_cmp = 0;
  int n_bad = 0;

  tone_contour_classifier dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(s0_start), .continuous_in(s0_cont),
    .frame_valid_in(s0_fv), .frame_data_in(s0_fd), .frame_ready_out(s0_rdy),
    .busy_out(s0_busy), .contour_out(s0_contour), .tone_ident_out(s0_tone),
    .valid_out(s0_valid)
  );

  tone_contour_classifier #(.DATA_W(32), .NUM_FRAMES(2)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(sa_start), .continuous_in(1'b0),
    .frame_valid_in(sa_fv), .frame_data_in(sa_fd), .frame_ready_out(sa_rdy),
    .busy_out(sa_busy), .contour_out(sa_contour), .tone_ident_out(sa_tone),
    .valid_out(sa_valid)
  );

  tone_contour_classifier #(.DATA_W(32), .NUM_FRAMES(16)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(sb_start), .continuous_in(1'b0),
    .frame_valid_in(sb_fv), .frame_data_in(sb_fd), .frame_ready_out(sb_rdy),
    .busy_out(sb_busy), .contour_out(sb_contour), .tone_ident_out(sb_tone),
    .valid_out(sb_valid)
  );

  // Reference decision straight from the percentage rule, in 64-bit arithmetic.
  function automatic logic [1:0] ref_code(input longint unsigned p, input longint unsigned c);
    longint unsigned d;
    d = (c > p) ? c - p : p - c;
    if (d == 0) return 2'b00;
    if (d * 100 >= p * 20) return (c > p) ? 2'b01 : 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ref_tone(input int r, input int f);
    if (r + f < 2) return 3'b000;
    if (f == 0 || r > f) return 3'b001;
    if (r == 0 || f > r) return 3'b100;
    return 3'b010;
  endfunction

  task automatic feed0(input logic [15:0] d);
    int w;
    w = 0;
    s0_fv = 1'b1;
    s0_fd = d;
    while (s0_rdy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 20) begin
      n_bad++;
      $display("FAIL feed0_ready: got %b want 1 within 20 cycles", s0_rdy);
    end
    @(negedge clk);
    s0_fv = 1'b0;
  endtask

  task automatic wait_valid0(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (s0_valid !== 1'b1 && lat < 20);
  endtask

  task automatic run_single(input logic [63:0] frames, input logic [5:0] exp_c,
                            input logic [2:0] exp_t, input string name,
                            input bit with_overlap);
    int lat;
    @(negedge clk);
    s0_start = 1'b1;
    s0_cont  = 1'b0;
    if (with_overlap) begin
      s0_fv = 1'b1;
      s0_fd = 16'd9999;
    end
    @(negedge clk);
    s0_start = 1'b0;
    s0_fv    = 1'b0;
    n_cmp++;
    if (s0_busy !== 1'b1 || s0_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s start: busy=%b ready=%b want 1/1", name, s0_busy, s0_rdy);
    end
    for (int i = 0; i < 4; i++) feed0(frames[16*i +: 16]);
    wait_valid0(lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    n_cmp++;
    if (s0_contour !== exp_c) begin
      n_bad++;
      $display("FAIL %s contour: got %b want %b", name, s0_contour, exp_c);
    end
    n_cmp++;
    if (s0_tone !== exp_t) begin
      n_bad++;
      $display("FAIL %s tone: got %b want %b", name, s0_tone, exp_t);
    end
    n_cmp++;
    if (s0_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: busy got %b want 0", name, s0_busy);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (s0_valid !== 1'b0 || s0_contour !== exp_c || s0_tone !== exp_t) begin
      n_bad++;
      $display("FAIL %s hold: valid=%b contour=%b tone=%b want 0/%b/%b",
               name, s0_valid, s0_contour, s0_tone, exp_c, exp_t);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s0_start = 1'b0; s0_cont = 1'b0; s0_fv = 1'b0; s0_fd = '0;
    sa_start = 1'b0; sa_fv = 1'b0; sa_fd = '0;
    sb_start = 1'b0; sb_fv = 1'b0; sb_fd = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s0_rdy, s0_busy, s0_contour, s0_tone, s0_valid} !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_dut0: rdy=%b busy=%b contour=%b tone=%b valid=%b want all 0",
               s0_rdy, s0_busy, s0_contour, s0_tone, s0_valid);
    end
    n_cmp++;
    if ({sa_busy, sa_valid, sb_busy, sb_valid, sb_contour} !== 34'b0) begin
      n_bad++;
      $display("FAIL reset_sweep: busy_a=%b busy_b=%b contour_b=%h want 0", sa_busy, sb_busy, sb_contour);
    end
    rst_n = 1'b1;
    // start ignored while in reset release cycle is not exercised; idle check only
    @(negedge clk);
    n_cmp++;
    if (s0_busy !== 1'b0 || s0_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_start: busy=%b ready=%b want 0/0", s0_busy, s0_rdy);
    end
  endtask

  task automatic test_single_shot();
    run_single({16'd220, 16'd170, 16'd130, 16'd100}, 6'b01_01_01, 3'b001, "rising", 1'b0);
    run_single({16'd80, 16'd110, 16'd150, 16'd200}, 6'b11_11_11, 3'b100, "falling", 1'b0);
    run_single({16'd100, 16'd105, 16'd110, 16'd100}, 6'b00_00_00, 3'b000, "small", 1'b0);
    run_single({16'd100, 16'd60, 16'd60, 16'd100}, 6'b01_00_11, 3'b010, "undulate", 1'b0);
    run_single({16'd5, 16'd5, 16'd0, 16'd0}, 6'b00_01_00, 3'b000, "from_zero", 1'b0);
    // 100->120 is exactly 20% (rise), 120->143 just under (flat); start overlaps a frame
    run_single({16'd100, 16'd143, 16'd120, 16'd100}, 6'b11_00_01, 3'b010, "threshold", 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    s0_start = 1'b1;
    @(negedge clk);
    s0_start = 1'b0;
    feed0(16'd100);
    feed0(16'd130);
    n_cmp++;
    if (s0_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_pre: busy got %b want 1", s0_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s0_rdy, s0_busy, s0_contour, s0_tone, s0_valid} !== 12'b0) begin
      n_bad++;
      $display("FAIL mid_reset_async: rdy=%b busy=%b contour=%b tone=%b valid=%b want all 0",
               s0_rdy, s0_busy, s0_contour, s0_tone, s0_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_single({16'd220, 16'd170, 16'd130, 16'd100}, 6'b01_01_01, 3'b001, "after_reset", 1'b0);
  endtask

  task automatic test_continuous();
    int lat;
    @(negedge clk);
    s0_start = 1'b1;
    s0_cont  = 1'b1;
    @(negedge clk);
    s0_start = 1'b0;
    s0_cont  = 1'b0;
    feed0(16'd100);
    feed0(16'd130);
    feed0(16'd170);
    feed0(16'd220);
    wait_valid0(lat);
    n_cmp++;
    if (lat !== 4 || s0_contour !== 6'b01_01_01 || s0_tone !== 3'b001) begin
      n_bad++;
      $display("FAIL cont_first: lat=%0d contour=%b tone=%b want 4/010101/001", lat, s0_contour, s0_tone);
    end
    n_cmp++;
    if (s0_busy !== 1'b1 || s0_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_rearm: busy=%b ready=%b want 1/1", s0_busy, s0_rdy);
    end
    feed0(16'd150);
    n_cmp++;
    if (s0_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_calc_ready: got %b want 0", s0_rdy);
    end
    wait_valid0(lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL cont_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (s0_contour !== 6'b11_01_01 || s0_tone !== 3'b001) begin
      n_bad++;
      $display("FAIL cont_second: contour=%b tone=%b want 110101/001", s0_contour, s0_tone);
    end
  endtask

  task automatic feed_a(input logic [31:0] d);
    int w;
    w = 0;
    sa_fv = 1'b1;
    sa_fd = d;
    while (sa_rdy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 20) begin
      n_bad++;
      $display("FAIL feed_a_ready: got %b want 1", sa_rdy);
    end
    @(negedge clk);
    sa_fv = 1'b0;
  endtask

  task automatic test_sweep_two();
    logic [31:0] pv [3];
    logic [31:0] cv [3];
    logic [1:0]  ec [3];
    int lat;
    pv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    cv = '{32'hCCCC_CCCC, 32'hCCCC_CCCD, 32'hFFFF_FFFF};
    ec = '{2'b11, 2'b00, 2'b01};
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      sa_start = 1'b1;
      @(negedge clk);
      sa_start = 1'b0;
      feed_a(pv[v]);
      feed_a(cv[v]);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (sa_valid !== 1'b1 && lat < 20);
      n_cmp++;
      if (lat !== 2 || sa_contour !== ec[v] || sa_tone !== 3'b000) begin
        n_bad++;
        $display("FAIL sweep2_%0d: lat=%0d contour=%b tone=%b want 2/%b/000",
                 v, lat, sa_contour, sa_tone, ec[v]);
      end
    end
  endtask

  task automatic test_sweep_sixteen();
    logic [31:0] fr [16];
    logic [29:0] exp_c;
    logic [1:0]  code;
    logic [2:0]  exp_t;
    int r, f, lat, w;
    fr = '{32'hFFFF_FFFF, 32'hCCCC_CCCC, 32'hCCCC_CCCC, 32'hFFFF_FFFF,
           32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001,
           32'h8000_0000, 32'h6666_6667, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
           32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h9000_0000, 32'hF000_0000};
    exp_c = '0;
    r = 0;
    f = 0;
    for (int k = 0; k < 15; k++) begin
      code = ref_code(longint'(fr[k]), longint'(fr[k+1]));
      exp_c[2*k +: 2] = code;
      if (code == 2'b01) r++;
      if (code == 2'b11) f++;
    end
    exp_t = ref_tone(r, f);
    @(negedge clk);
    sb_start = 1'b1;
    @(negedge clk);
    sb_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = 0;
      sb_fv = 1'b1;
      sb_fd = fr[i];
      while (sb_rdy !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      n_cmp++;
      if (w >= 20) begin
        n_bad++;
        $display("FAIL feed_b_ready: frame %0d not accepted", i);
      end
      @(negedge clk);
      sb_fv = 1'b0;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (sb_valid !== 1'b1 && lat < 40);
    n_cmp++;
    if (lat !== 16) begin
      n_bad++;
      $display("FAIL sweep16_latency: got %0d want 16", lat);
    end
    n_cmp++;
    if (sb_contour !== exp_c) begin
      n_bad++;
      $display("FAIL sweep16_contour: got %b want %b", sb_contour, exp_c);
    end
    n_cmp++;
    if (sb_tone !== exp_t) begin
      n_bad++;
      $display("FAIL sweep16_tone: got %b want %b", sb_tone, exp_t);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_mid_reset();
    test_continuous();
    test_sweep_two();
    test_sweep_sixteen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach the summary in time");
    $fatal(1);
  end

endmodule

// File: doc/tone_contour_classifier.md
# tone_contour_classifier

Parametrised successor to the fixed four-frame tone detector. It takes one pitch estimate per FFT frame, typically the peak-bin index from the upstream peak picker. It keeps a window of `NUM_FRAMES` estimates, classifies each adjacent pair as rise, fall or flat against a percentage threshold using no divider, and reduces the segment codes to a tone identifier. It sits between the FFT peak picker and the tone/word decision logic, and supports a single-shot mode and a sliding-window continuous mode.

## Interface
- `DATA_W`, default 16: width of the unsigned pitch estimate.
- `NUM_FRAMES`, default 4: window depth, 2..16. The segment count is `SEGS = NUM_FRAMES-1`.
- `THRESH_PCT`, default 20: percent change that counts as significant, 1..100.

Ports:
- `clk_in` in, 1: the single clock.
- `rst_n_in` in, 1: asynchronous, active-low reset.
- `start_in` in, 1: arms a capture. Sampled only in IDLE.
- `continuous_in` in, 1: 1 selects sliding-window mode. Latched on start.
- `frame_valid_in` in, 1: a frame estimate is present.
- `frame_data_in` in, DATA_W: unsigned pitch estimate.
- `frame_ready_out` out, 1: the block accepts a frame this cycle.
- `busy_out` out, 1: high in any state other than IDLE.
- `contour_out` out, 2*SEGS: segment codes. Segment k sits at bits [2k+1:2k], and k=0 is the oldest pair.
- `tone_ident_out` out, 3: classification result.
- `valid_out` out, 1: one-cycle pulse when `contour_out` and `tone_ident_out` update.

## Operation
- **States:** IDLE, CAPTURE, CALC, REPORT.
- **IDLE:** on `start_in`, latch `continuous_in`, clear the frame count, go to CAPTURE.
- **CAPTURE:**
  - `frame_ready_out`=1.
  - Each `frame_valid_in`&&ready shifts the value into the window (newest at index NUM_FRAMES-1) and increments the count.
  - When the count reaches NUM_FRAMES, go to CALC.
- **CALC:**
  - Evaluates one segment per cycle, k=0..SEGS-1, using a segment counter.
  - For prev=w[k] and cur=w[k+1]: significant iff |cur-prev|*100 >= THRESH_PCT*prev.
  - Products are DATA_W+7 bits wide, unsigned, and must not overflow.
  - If prev=0, any cur≠0 is significant.
  - Code per segment: 2'b01 rise, 2'b11 fall, 2'b00 flat or insignificant.
  - Also counts rises R and falls F.
- **REPORT:**
  - Update `contour_out` and `tone_ident_out`, and pulse `valid_out`.
  - Single-shot mode: go to IDLE.
  - Continuous mode: go to CAPTURE with the count set to NUM_FRAMES-1, so only one new frame triggers the next CALC.
- **Classification:**
  - R+F<2: NEUTRAL 3'b000.
  - Else F==0 or R>F: RISING 3'b001.
  - Else R==0 or F>R: FALLING 3'b100.
  - Else (R==F≥1): UNDULATING 3'b010.
- `start_in` is ignored while busy. Frames offered outside CAPTURE are not accepted.

## Timing
- Reset values: `frame_ready_out`=0, `busy_out`=0, `contour_out`=0, `tone_ident_out`=3'b000, `valid_out`=0. The reset also clears the window, the counters and the latched mode.
- Start is sampled at edge t. CAPTURE and ready are asserted from t+1.
- Latency from acceptance of the last frame (edge a) to `valid_out` high: SEGS+1 cycles. CALC occupies a+1..a+SEGS, and REPORT drives `valid_out` at a+SEGS+1.
- Continuous mode: `frame_ready_out` is 0 during CALC and REPORT, and the maximum frame rate is one per SEGS+2 cycles. Upstream holds `frame_valid_in` until ready.
- Outputs hold their last value between reports.
- Asserting `rst_n_in` mid-operation returns the block to IDLE immediately. No `valid_out` is produced for the partial window.
- If `start_in` and `frame_valid_in` arrive in the same IDLE cycle, the frame is not accepted.

## Structure
- `tone_pkg` holds:
  - `typedef enum logic [2:0]` for the tone identifiers NEUTRAL, RISING, UNDULATING, FALLING;
  - `localparam` segment codes SEG_FLAT, SEG_RISE, SEG_FALL;
  - the state enum.
- One sub-module, `tone_change_detector`, is natural: purely combinational. It takes prev, cur and THRESH_PCT and outputs a 2-bit code. It is instantiated once and time-shared across segments by CALC.

## Test plan
- Defaults, single-shot, frames 100,130,170,220 -> contour 6'b01_01_01, tone 3'b001, `valid_out` 4 cycles after the last accept.
- Frames 200,150,110,80 -> contour 6'b11_11_11, tone 3'b100. Frames 100,110,105,100 (all changes <20%) -> contour 0, tone 3'b000.
- Frames 100,60,60,100 -> contour 6'b01_00_11, tone 3'b010. Frames 0,0,5,5 -> segment 1 rise only, tone 3'b000.
- Continuous mode with NUM_FRAMES=4, feed 100,130,170,220 then 150 -> second report contour 6'b11_01_01, tone 3'b001, with a 5th-frame-to-valid latency of 4 cycles.
- Parameter sweep NUM_FRAMES=2 and 16, DATA_W=32, frame values near 2^32-1 -> no overflow, results match the scoreboard.
- `rst_n_in` low after 2 frames -> all outputs at reset values asynchronously. After release, a new start plus 4 frames gives a correct report.
